lsunit: RTL and testbench

Load/store execution unit at the far end of the load/store issue queue's `issuels_*` interface. It accepts one ready memory instruction at a time and performs the data-memory access. For loads, it publishes the loaded word on the common data bus (CDB) under the instruction's destination tag. It is a three-state controller sitting between the load/store issue queue, the data memory port and the CDB arbiter.

---
 rtl/lsunit.sv | 133 +++++++++++++
 tb/tb_lsunit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsunit.sv
// rtl/lsunit.sv - load/store execution unit: issue accept, data-memory access, CDB publish.
// Optional misaligned-access detection is enabled by defining LSUNIT_ALIGN_CHECK_EN.
`ifndef ISSUELS_FUNC_SW
`define ISSUELS_FUNC_SW 1'b1
`endif

module lsunit (
  input  logic        clk,
  input  logic        reset,
  input  logic        issuels_opcode,
  input  logic [5:0]  issuels_rttag,
  input  logic [31:0] issuels_addr,
  input  logic [31:0] issuels_data,
  input  logic        issuels_ready,
  output logic        issuels_done,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        lsu_cdb_req,
  output logic [5:0]  lsu_cdb_tag,
  output logic [31:0] lsu_cdb_data,
  input  logic        lsu_cdb_grant,
  output logic        lsu_exc
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_CDB} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [5:0]  tag_q, tag_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_store;

  assign is_store = (issuels_opcode == `ISSUELS_FUNC_SW);

`ifdef LSUNIT_ALIGN_CHECK_EN
  logic exc_q, exc_d;
  logic misaligned;
  assign misaligned = (issuels_addr[1:0] != 2'b00);
  assign lsu_exc    = exc_q;
`else
  assign lsu_exc    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    tag_d        = tag_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    issuels_done = 1'b0;
`ifdef LSUNIT_ALIGN_CHECK_EN
    exc_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        issuels_done = issuels_ready & ~reset;
        if (issuels_done) begin
          // Only the operand relevant to the opcode is captured, so the unused one cannot leak out.
          we_d    = is_store;
          addr_d  = issuels_addr;
          state_d = S_MEM;
          if (is_store) wdata_d = issuels_data;
          else          tag_d   = issuels_rttag;
`ifdef LSUNIT_ALIGN_CHECK_EN
          if (misaligned) begin
            exc_d   = 1'b1;
            state_d = is_store ? S_IDLE : S_CDB;
            if (!is_store) rdata_d = 32'h0;
          end
`endif
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = dmem_rdata;
            state_d = S_CDB;
          end
        end
      end
      S_CDB: begin
`ifdef LSUNIT_ALIGN_CHECK_EN
        exc_d = exc_q & ~lsu_cdb_grant;
`endif
        if (lsu_cdb_grant) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      tag_q   <= 6'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef LSUNIT_ALIGN_CHECK_EN
      exc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef LSUNIT_ALIGN_CHECK_EN
      exc_q   <= exc_d;
`endif
    end
  end

  // Write strobe and data are qualified by MEM so they read 0 whenever no store is in flight.
  assign dmem_req     = (state_q == S_MEM);
  assign dmem_we      = dmem_req & we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = dmem_we ? wdata_q : 32'h0;
  assign lsu_cdb_req  = (state_q == S_CDB);
  assign lsu_cdb_tag  = tag_q;
  assign lsu_cdb_data = rdata_q;

endmodule

// File: tb/tb_lsunit.sv
// tb/tb_lsunit.sv - directed table-driven bench for lsunit (default build; LSUNIT_ALIGN_CHECK_EN optional).
`ifndef ISSUELS_FUNC_SW
`define ISSUELS_FUNC_SW 1'b1
`endif

module tb_lsunit;

  logic        clk = 1'b0;
  logic        reset;
  logic        issuels_opcode;
  logic [5:0]  issuels_rttag;
  logic [31:0] issuels_addr;
  logic [31:0] issuels_data;
  logic        issuels_ready;
  logic        issuels_done;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        lsu_cdb_req;
  logic [5:0]  lsu_cdb_tag;
  logic [31:0] lsu_cdb_data;
  logic        lsu_cdb_grant;
  logic        lsu_exc;

  int n_cmp  = 0;
  int n_fail = 0;

  lsunit dut (
    .clk(clk), .reset(reset),
    .issuels_opcode(issuels_opcode), .issuels_rttag(issuels_rttag),
    .issuels_addr(issuels_addr), .issuels_data(issuels_data),
    .issuels_ready(issuels_ready), .issuels_done(issuels_done),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .lsu_cdb_req(lsu_cdb_req), .lsu_cdb_tag(lsu_cdb_tag),
    .lsu_cdb_data(lsu_cdb_data), .lsu_cdb_grant(lsu_cdb_grant),
    .lsu_exc(lsu_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [5:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          ack_dly;
    int          gnt_dly;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        exp_cdb;
    logic [5:0]  exp_tag;
    logic [31:0] exp_cdb_data;
  } vec_t;

  vec_t v_tab[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge where it is back in IDLE.
  task automatic run_vec(input vec_t v);
    issuels_opcode = v.op;
    issuels_rttag  = v.tag;
    issuels_addr   = v.addr;
    issuels_data   = v.data;
    issuels_ready  = 1'b1;
    #1;
    chk("accept_done", {31'b0, issuels_done}, 32'd1);
    for (int i = 0; i <= v.ack_dly; i++) begin
      @(negedge clk);
      chk("mem_req", {31'b0, dmem_req}, 32'd1);
      chk("mem_we", {31'b0, dmem_we}, {31'b0, v.exp_we});
      chk("mem_addr", dmem_addr, v.addr);
      chk("mem_wdata", dmem_wdata, v.exp_wdata);
      chk("mem_done_low", {31'b0, issuels_done}, 32'd0);
      chk("mem_cdb_low", {31'b0, lsu_cdb_req}, 32'd0);
      dmem_ack   = (i == v.ack_dly);
      dmem_rdata = (i == v.ack_dly) ? v.rdata : ~v.rdata;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    if (v.exp_cdb) begin
      for (int j = 0; j <= v.gnt_dly; j++) begin
        if (j > 0) @(negedge clk);
        chk("cdb_req", {31'b0, lsu_cdb_req}, 32'd1);
        chk("cdb_tag", {26'b0, lsu_cdb_tag}, {26'b0, v.exp_tag});
        chk("cdb_data", lsu_cdb_data, v.exp_cdb_data);
        chk("cdb_mem_low", {31'b0, dmem_req}, 32'd0);
        chk("cdb_done_low", {31'b0, issuels_done}, 32'd0);
        lsu_cdb_grant = (j == v.gnt_dly);
      end
      @(negedge clk);
      lsu_cdb_grant = 1'b0;
    end
    issuels_ready = 1'b0;
    chk("idle_cdb_low", {31'b0, lsu_cdb_req}, 32'd0);
    chk("idle_req_low", {31'b0, dmem_req}, 32'd0);
    chk("idle_we_low", {31'b0, dmem_we}, 32'd0);
    chk("idle_wdata_zero", dmem_wdata, 32'h0);
    chk("idle_exc_low", {31'b0, lsu_exc}, 32'd0);
  endtask

  initial begin
    int done_cyc[$];
    int cdb_cnt;
    v_tab[0] = '{1'b0, 6'h2A, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, 1'b1, 6'h2A, 32'hDEAD_BEEF};
    v_tab[1] = '{`ISSUELS_FUNC_SW, 6'h15, 32'h0000_0204, 32'h1234_5678, 32'h0, 3, 0, 1'b1, 32'h1234_5678, 1'b0, 6'h0, 32'h0};
    v_tab[2] = '{1'b0, 6'h01, 32'h0000_0000, 32'h5555_AAAA, 32'hFFFF_FFFF, 2, 3, 1'b0, 32'h0, 1'b1, 6'h01, 32'hFFFF_FFFF};
    v_tab[3] = '{`ISSUELS_FUNC_SW, 6'h3F, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h0, 0, 0, 1'b1, 32'hA5A5_A5A5, 1'b0, 6'h0, 32'h0};
    v_tab[4] = '{1'b0, 6'h3F, 32'h0000_0108, 32'hFFFF_0000, 32'h0000_1234, 1, 1, 1'b0, 32'h0, 1'b1, 6'h3F, 32'h0000_1234};

    reset = 1'b1; issuels_ready = 1'b1; issuels_opcode = 1'b0; issuels_rttag = 6'h2A;
    issuels_addr = 32'h100; issuels_data = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    lsu_cdb_grant = 1'b0;
    #1;
    chk("reset_done_low", {31'b0, issuels_done}, 32'd0);
    @(negedge clk);
    chk("reset_done_low2", {31'b0, issuels_done}, 32'd0);
    chk("reset_outs", {dmem_req, dmem_we, lsu_cdb_req, lsu_exc, 28'b0}, 32'h0);
    chk("reset_addr", dmem_addr, 32'h0);
    chk("reset_wdata", dmem_wdata, 32'h0);
    chk("reset_tag", {26'b0, lsu_cdb_tag}, 32'h0);
    chk("reset_cdb_data", lsu_cdb_data, 32'h0);
    reset = 1'b0; issuels_ready = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(v_tab[k]);

    // Back-to-back load then store with ready held high and grant withheld for five cycles.
    issuels_opcode = 1'b0; issuels_rttag = 6'h11; issuels_addr = 32'h300;
    issuels_data = 32'h0; issuels_ready = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    cdb_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done_cyc.size() == 1) begin
        issuels_opcode = `ISSUELS_FUNC_SW; issuels_addr = 32'h304; issuels_data = 32'h7777_8888;
      end
      if (done_cyc.size() == 2) issuels_ready = 1'b0;
      dmem_ack      = dmem_req;
      lsu_cdb_grant = lsu_cdb_req && (cdb_cnt == 5);
      if (lsu_cdb_req) cdb_cnt++;
      #1;
      if (issuels_done) done_cyc.push_back(cyc);
    end
    chk("b2b_done_count", done_cyc.size(), 32'd2);
    if (done_cyc.size() == 2) begin
      chk("b2b_first", done_cyc[0], 32'd0);
      chk("b2b_second", done_cyc[1], 32'd8);
    end
    @(negedge clk);
    dmem_ack = 1'b0; lsu_cdb_grant = 1'b0;

    // Reset while a load result waits in CDB.
    issuels_opcode = 1'b0; issuels_rttag = 6'h0C; issuels_addr = 32'h400; issuels_ready = 1'b1;
    @(negedge clk);
    issuels_ready = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("rst_mid_cdb_req", {31'b0, lsu_cdb_req}, 32'd1);
    chk("rst_mid_cdb_data", lsu_cdb_data, 32'hCAFE_0001);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; lsu_cdb_grant = 1'b1;
    #1;
    chk("rst_mid_cdb_low", {31'b0, lsu_cdb_req}, 32'd0);
    chk("rst_mid_mem_low", {31'b0, dmem_req}, 32'd0);
    @(negedge clk);
    lsu_cdb_grant = 1'b0;
    chk("rst_mid_grant_ignored", {31'b0, lsu_cdb_req, dmem_req}, 32'd0);
    run_vec(v_tab[0]);

`ifdef LSUNIT_ALIGN_CHECK_EN
    issuels_opcode = 1'b0; issuels_rttag = 6'h22; issuels_addr = 32'h102; issuels_ready = 1'b1;
    @(negedge clk);
    issuels_ready = 1'b0;
    chk("mis_ld_no_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_ld_cdb_req", {31'b0, lsu_cdb_req}, 32'd1);
    chk("mis_ld_data", lsu_cdb_data, 32'h0);
    chk("mis_ld_exc", {31'b0, lsu_exc}, 32'd1);
    @(negedge clk);
    chk("mis_ld_exc_hold", {31'b0, lsu_exc}, 32'd1);
    lsu_cdb_grant = 1'b1;
    @(negedge clk);
    lsu_cdb_grant = 1'b0;
    chk("mis_ld_exc_clr", {31'b0, lsu_exc, lsu_cdb_req}, 32'd0);
    issuels_opcode = `ISSUELS_FUNC_SW; issuels_addr = 32'h103; issuels_data = 32'h9999_0000; issuels_ready = 1'b1;
    @(negedge clk);
    issuels_ready = 1'b0;
    chk("mis_st_exc", {31'b0, lsu_exc}, 32'd1);
    chk("mis_st_no_write", {30'b0, dmem_req, dmem_we}, 32'd0);
    @(negedge clk);
    chk("mis_st_exc_pulse", {31'b0, lsu_exc}, 32'd0);
    chk("mis_st_no_write2", {30'b0, dmem_req, dmem_we}, 32'd0);
`else
    issuels_opcode = 1'b0; issuels_rttag = 6'h22; issuels_addr = 32'h102; issuels_ready = 1'b1;
    @(negedge clk);
    issuels_ready = 1'b0;
    chk("unaligned_req", {31'b0, dmem_req}, 32'd1);
    chk("unaligned_addr", dmem_addr, 32'h102);
    chk("unaligned_exc", {31'b0, lsu_exc}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h0102_0304;
    @(negedge clk);
    dmem_ack = 1'b0; lsu_cdb_grant = 1'b1;
    chk("unaligned_cdb_data", lsu_cdb_data, 32'h0102_0304);
    chk("unaligned_cdb_exc", {31'b0, lsu_exc}, 32'd0);
    @(negedge clk);
    lsu_cdb_grant = 1'b0;
    chk("unaligned_idle", {31'b0, lsu_cdb_req}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
